regfile_responder: RTL and testbench

- Register-file responder for the CPU register interface: services the CPU's register-port requests (ra, rb, rdata, rw) and returns rav/rbv.
- Storage is block-RAM style. Two duplicated banks give two read ports; both banks are written on every write.
- After reset, a sequencer zeroes every entry because BRAM contents cannot be async-reset. Readiness is reported on `locked`, which drives the CPU's `locked` input.
- Sits beside the CPU in the machine top, in place of the bench-level register array.

---
 rtl/regfile_responder.sv | 112 +++++++++++
 tb/tb_regfile_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regfile_responder.sv
// Register-file responder: two duplicated BRAM-style banks, cleared after reset.
// Ports: clock/resetn, ra/rb read idx (ra also write idx), rdata/rw write, rav/rbv data, locked, clr_cnt.
module regfile_responder #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rw,
  output logic [DATA_W-1:0] rav,
  output logic [DATA_W-1:0] rbv,
  output logic              locked,
  output logic [ADDR_W-1:0] clr_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic              za, zb, acc;
  logic [DATA_W-1:0] rav_d, rbv_d;

  logic [DATA_W-1:0] bank_a [DEPTH];
  logic [DATA_W-1:0] bank_b [DEPTH];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (cnt_q == LAST) state_d = READY;
        else cnt_d = cnt_q + 1'b1;
      end
      READY: begin
        state_d = READY;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Ready-state write is dropped for index 0 when the zero register is on.
  assign za  = (ZERO_REG != 0) && (ra == '0);
  assign zb  = (ZERO_REG != 0) && (rb == '0);
  assign acc = locked && rw && !za;

  always_comb begin
    locked = (state_q == READY);
    we     = 1'b1;
    waddr  = cnt_q;
    wdata  = '0;
    if (state_q == READY) begin
      we    = acc;
      waddr = ra;
      wdata = rdata;
    end
  end

  assign clr_cnt = cnt_q;

  always_ff @(posedge clock) begin
    if (we) begin
      bank_a[waddr] <= wdata;
      bank_b[waddr] <= wdata;
    end
  end

  // Banks are read-first, so a same-edge write is forwarded from rdata.
  always_comb begin
    rav_d = bank_a[ra];
    rbv_d = bank_b[rb];
    if (acc) rav_d = rdata;
    if (acc && rb == ra) rbv_d = rdata;
    if (za) rav_d = '0;
    if (zb) rbv_d = '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rav <= '0;
      rbv <= '0;
    end else if (!locked) begin
      rav <= '0;
      rbv <= '0;
    end else begin
      rav <= rav_d;
      rbv <= rbv_d;
    end
  end

endmodule

// File: tb/tb_regfile_responder.sv
// Self-checking bench for regfile_responder: reference model plus directed checks.
// Drives inputs on negedge, checks outputs 1 time unit after posedge.
module tb_regfile_responder;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic [7:0]  ra = '0;
  logic [7:0]  rb = '0;
  logic [31:0] rdata = '0;
  logic        rw = 1'b0;
  logic [31:0] rav, rbv;
  logic        locked;
  logic [7:0]  clr_cnt;

  int pass_cnt = 0;
  int total = 0;
  bit chk_en = 1'b0;

  logic [31:0] mem [256];
  int          rel = 0;

  regfile_responder #(.ADDR_W(8), .DATA_W(32), .ZERO_REG(1)) dut (
    .clock  (clock),
    .resetn (resetn),
    .ra     (ra),
    .rb     (rb),
    .rdata  (rdata),
    .rw     (rw),
    .rav    (rav),
    .rbv    (rbv),
    .locked (locked),
    .clr_cnt(clr_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s got %h want %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  // Model: after 256 released edges the file is usable and all zero.
  always @(posedge clock) begin
    if (chk_en) begin
      logic [31:0] e_a, e_b, e_clr;
      logic        e_lk;
      logic [7:0]  a, b;
      logic [31:0] d;
      logic        w;
      a = ra; b = rb; d = rdata; w = rw;
      if (!resetn) begin
        rel = 0;
        e_a = 0; e_b = 0;
      end else if (rel < 256) begin
        e_a = 0; e_b = 0;
        rel++;
        if (rel == 256)
          for (int i = 0; i < 256; i++) mem[i] = 0;
      end else begin
        e_a = (a == 0) ? 32'd0 : (w ? d : mem[a]);
        e_b = (b == 0) ? 32'd0 :
              ((w && a != 0 && b == a) ? d : mem[b]);
        if (w && a != 0) mem[a] = d;
      end
      e_lk  = (rel >= 256);
      e_clr = (rel >= 255) ? 32'd255 : 32'(rel);
      #1;
      chk("m_rav", rav, e_a);
      chk("m_rbv", rbv, e_b);
      chk("m_locked", {31'd0, locked}, {31'd0, e_lk});
      chk("m_clr_cnt", {24'd0, clr_cnt}, e_clr);
    end
  end

  task automatic cyc(input logic w, input logic [7:0] a,
                     input logic [7:0] b, input logic [31:0] d);
    @(negedge clock);
    rw = w; ra = a; rb = b; rdata = d;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_lock();
    int n;
    n = 0;
    @(negedge clock);
    resetn = 1'b1;
    while (n < 400) begin
      @(posedge clock);
      #1;
      n++;
      if (locked) break;
    end
    chk("lock_cycles", 32'(n), 32'd256);
  endtask

  initial begin
    #2 resetn = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_clr", {24'd0, clr_cnt}, 32'd0);
    chk("rst_rav", rav, 32'd0);
    // Clear sequence with a write attempt held on the bus
    @(negedge clock);
    rw = 1'b1; ra = 8'd5; rb = 8'd5; rdata = 32'hDEADBEEF;
    wait_lock();
    cyc(1'b0, 8'd5, 8'd5, 32'd0);
    chk("clr_reg5_a", rav, 32'd0);
    chk("clr_reg5_b", rbv, 32'd0);
    for (int i = 0; i < 256; i++)
      cyc(1'b0, 8'(i), 8'(255 - i), 32'd0);
    // Write then read
    cyc(1'b1, 8'h10, 8'h00, 32'h12345678);
    cyc(1'b0, 8'h10, 8'h10, 32'd0);
    chk("rd_rav", rav, 32'h12345678);
    chk("rd_rbv", rbv, 32'h12345678);
    // Same-edge forwarding
    cyc(1'b1, 8'h20, 8'h20, 32'hCAFEF00D);
    chk("fwd_rav", rav, 32'hCAFEF00D);
    chk("fwd_rbv", rbv, 32'hCAFEF00D);
    // Zero register
    cyc(1'b1, 8'h00, 8'h00, 32'hFFFFFFFF);
    chk("z_fwd_rav", rav, 32'd0);
    chk("z_fwd_rbv", rbv, 32'd0);
    cyc(1'b0, 8'h00, 8'h00, 32'd0);
    chk("z_rd_rav", rav, 32'd0);
    chk("z_rd_rbv", rbv, 32'd0);
    // Randomized traffic, narrow indices half the time to collide
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] a, b;
      a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      b = ($urandom_range(0, 2) == 0) ? a :
          (($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom));
      cyc(1'($urandom_range(0, 1)), a, b, $urandom);
    end
    // Reset mid-use
    cyc(1'b1, 8'd3, 8'd0, 32'h55);
    cyc(1'b0, 8'd3, 8'd3, 32'd0);
    chk("use_wr3", rav, 32'h55);
    @(negedge clock);
    rw = 1'b0;
    resetn = 1'b0;
    #1;
    chk("use_rst_lk", {31'd0, locked}, 32'd0);
    chk("use_rst_rav", rav, 32'd0);
    // Reset mid-clear at clr_cnt = 100
    @(negedge clock);
    resetn = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (clr_cnt == 8'd100) break;
    end
    chk("mid_reached", {24'd0, clr_cnt}, 32'd100);
    resetn = 1'b0;
    #1;
    chk("mid_clr", {24'd0, clr_cnt}, 32'd0);
    chk("mid_locked", {31'd0, locked}, 32'd0);
    @(negedge clock);
    wait_lock();
    cyc(1'b0, 8'd3, 8'd3, 32'd0);
    chk("use_reg3_a", rav, 32'd0);
    chk("use_reg3_b", rbv, 32'd0);
    cyc(1'b0, 8'h10, 8'h20, 32'd0);
    chk("use_reg10", rav, 32'd0);
    chk("use_reg20", rbv, 32'd0);
    @(negedge clock);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
